guitar_input_conditioner: RTL and testbench

- Sits between the guitar controller GPIO pins and the gameplay note comparator.
- Synchronises and debounces the five fret buttons and the strum bar.
- Converts each strum into one single-cycle event carrying a snapshot of the frets held at that moment.
- Applies a strum lockout window, suppresses strums while paused, and keeps a wrapping count of accepted strums for LED/debug use.

---
 rtl/guitar_input_conditioner.sv | 117 +++++++++++
 tb/tb_guitar_input_conditioner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/guitar_input_conditioner.sv
// Guitar controller front end: synchronises and debounces fret/strum pins and turns
// each accepted strum into a single-cycle event carrying a fret snapshot.
module guitar_input_conditioner #(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int LOCKOUT_CYCLES   = 2500000,
    parameter bit STRUM_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] buttons_raw,
    input  logic       strum_raw,
    input  logic       pause,
    output logic [4:0] buttons_clean,
    output logic       strum_held,
    output logic       strum_pulse,
    output logic [4:0] strum_frets,
    output logic [7:0] strum_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LK_W = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] LOCKOUT = 1'b1;

    logic [5:0]      sync_p0;
    logic [5:0]      sync_p1;
    logic [5:0]      level_p1;
    logic [5:0]      clean_p2;
    logic [DB_W-1:0] db_cnt_p2 [6];
    logic            held_prev_p3;
    logic            press_p2;
    logic [0:0]      state;
    logic [LK_W-1:0] lock_cnt;
    logic            vld_p3;
    logic [4:0]      frets_p3;
    logic [7:0]      count_p3;

    // Stage p0/p1: two-flop synchronisers, bit 5 is the strum pin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {strum_raw, buttons_raw};
            sync_p1 <= sync_p0;
        end
    end

    assign level_p1 = {sync_p1[5] ^ STRUM_ACTIVE_LOW, sync_p1[4:0]};

    // Stage p2: per-channel debounce, a flip needs DEBOUNCE_CYCLES mismatching samples in a row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clean_p2 <= '0;
            for (int i = 0; i < 6; i++) begin
                db_cnt_p2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (level_p1[i] == clean_p2[i]) begin
                    db_cnt_p2[i] <= '0;
                end else if (db_cnt_p2[i] == DB_LAST) begin
                    clean_p2[i]  <= level_p1[i];
                    db_cnt_p2[i] <= '0;
                end else begin
                    db_cnt_p2[i] <= db_cnt_p2[i] + DB_W'(1);
                end
            end
        end
    end

    assign press_p2 = clean_p2[5] & ~held_prev_p3;

    // Stage p3: strum acceptance with lockout; the snapshot samples the same registered cycle as the press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_prev_p3 <= 1'b0;
            state        <= IDLE;
            lock_cnt     <= '0;
            vld_p3       <= 1'b0;
            frets_p3     <= '0;
            count_p3     <= '0;
        end else begin
            held_prev_p3 <= clean_p2[5];
            vld_p3       <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_p2 && !pause) begin
                        vld_p3   <= 1'b1;
                        frets_p3 <= clean_p2[4:0];
                        count_p3 <= count_p3 + 8'd1;
                        lock_cnt <= LK_LOAD;
                        state    <= LOCKOUT;
                    end
                end
                LOCKOUT: begin
                    if (lock_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt - LK_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign buttons_clean = clean_p2[4:0];
    assign strum_held    = clean_p2[5];
    assign strum_pulse   = vld_p3;
    assign strum_frets   = frets_p3;
    assign strum_count   = count_p3;

endmodule

// File: tb/tb_guitar_input_conditioner.sv
// Scoreboard bench for guitar_input_conditioner with short debounce/lockout windows.
module tb_guitar_input_conditioner;

    logic       clk;
    logic       reset;
    logic [4:0] buttons_raw;
    logic       strum_raw;
    logic       pause;
    logic [4:0] buttons_clean;
    logic       strum_held;
    logic       strum_pulse;
    logic [4:0] strum_frets;
    logic [7:0] strum_count;

    guitar_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .LOCKOUT_CYCLES  (8),
        .STRUM_ACTIVE_LOW(1'b0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .buttons_raw  (buttons_raw),
        .strum_raw    (strum_raw),
        .pause        (pause),
        .buttons_clean(buttons_clean),
        .strum_held   (strum_held),
        .strum_pulse  (strum_pulse),
        .strum_frets  (strum_frets),
        .strum_count  (strum_count)
    );

    typedef struct {
        logic [4:0] frets;
        logic [7:0] count;
        int         cyc;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_count = 8'd0;
    int         base;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [4:0] f, input int at_cyc);
        exp_count = exp_count + 8'd1;
        sb_q.push_back('{frets: f, count: exp_count, cyc: at_cyc});
    endtask

    task automatic do_strum(input logic [4:0] f);
        buttons_raw = f;
        tick(8);
        strum_raw = 1'b1;
        expect_pulse(f, cyc + 7);
        tick(10);
        strum_raw = 1'b0;
        tick(8);
    endtask

    // Monitor: pops one expectation per pulse the DUT presents
    always @(negedge clk) begin
        if (!reset && strum_pulse) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_cycle", cyc, mon_e.cyc);
                check("strum_frets", {27'd0, strum_frets}, {27'd0, mon_e.frets});
                check("strum_count", {24'd0, strum_count}, {24'd0, mon_e.count});
            end
        end
    end

    initial begin
        reset       = 1'b1;
        buttons_raw = 5'b00000;
        strum_raw   = 1'b0;
        pause       = 1'b0;
        tick(3);
        check("reset_outputs", {13'd0, buttons_clean, strum_held, strum_pulse, strum_frets, strum_count}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Fret debounce, clean and with a one-cycle glitch
        base = cyc;
        buttons_raw = 5'b00101;
        tick(5);
        check("fret_debounce_early", {27'd0, buttons_clean}, 32'h00);
        tick(1);
        check("fret_debounce_flip", {27'd0, buttons_clean}, 32'h05);
        buttons_raw = 5'b00000;
        tick(8);
        check("fret_release", {27'd0, buttons_clean}, 32'h00);
        buttons_raw = 5'b00101;
        tick(3);
        buttons_raw = 5'b00000;
        tick(1);
        buttons_raw = 5'b00101;
        tick(5);
        check("fret_glitch_early", {27'd0, buttons_clean}, 32'h00);
        tick(1);
        check("fret_glitch_flip", {27'd0, buttons_clean}, 32'h05);

        // Basic strum
        buttons_raw = 5'b10010;
        tick(8);
        base = cyc;
        strum_raw = 1'b1;
        expect_pulse(5'b10010, base + 7);
        tick(5);
        check("strum_held_early", {31'd0, strum_held}, 32'd0);
        tick(1);
        check("strum_held_rise", {31'd0, strum_held}, 32'd1);
        tick(10);
        strum_raw = 1'b0;
        tick(8);

        // Lockout: second press lands inside the window, third after it
        base = cyc;
        strum_raw = 1'b1;
        expect_pulse(5'b10010, base + 7);
        tick(4);
        strum_raw = 1'b0;
        tick(4);
        strum_raw = 1'b1;
        tick(4);
        strum_raw = 1'b0;
        tick(4);
        strum_raw = 1'b1;
        expect_pulse(5'b10010, base + 23);
        tick(10);
        strum_raw = 1'b0;
        tick(8);

        // Pause drops the press and it is not replayed
        pause = 1'b1;
        strum_raw = 1'b1;
        tick(10);
        pause = 1'b0;
        tick(6);
        check("pause_count", {24'd0, strum_count}, {24'd0, exp_count});
        strum_raw = 1'b0;
        tick(8);
        do_strum(5'b10010);

        // Bounce: 2-cycle runs never qualify, the final settle does
        buttons_raw = 5'b01100;
        tick(8);
        for (int i = 0; i < 10; i++) begin
            strum_raw = ~strum_raw;
            tick(2);
        end
        base = cyc;
        strum_raw = 1'b1;
        expect_pulse(5'b01100, base + 7);
        tick(10);
        strum_raw = 1'b0;
        tick(8);

        // Frets changing one cycle after the strum: snapshot keeps the old frets
        buttons_raw = 5'b00011;
        tick(8);
        base = cyc;
        strum_raw = 1'b1;
        expect_pulse(5'b00011, base + 7);
        tick(1);
        buttons_raw = 5'b11000;
        tick(10);
        strum_raw = 1'b0;
        tick(8);

        // Count up to the wrap point
        while (exp_count != 8'd254) do_strum(5'b00001);
        do_strum(5'b10101);
        do_strum(5'b01010);

        // Reset in the middle of a lockout with strum held through release
        base = cyc;
        strum_raw = 1'b1;
        expect_pulse(5'b01010, base + 7);
        tick(9);
        #2 reset = 1'b1;
        #1;
        check("async_reset_clean", {26'd0, buttons_clean, strum_held}, 32'd0);
        check("async_reset_strum", {18'd0, strum_pulse, strum_frets, strum_count}, 32'd0);
        tick(3);
        reset = 1'b0;
        exp_count = 8'd0;
        expect_pulse(5'b01010, cyc + 7);
        tick(25);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
